// File: rtl/fetch_queue_pkg.sv
// Shared types for the parametrised fetch queue: entry payload, control states
// and the leading-ones helper used to count accepted fetch / retired decode lanes.
package fetch_queue_pkg;

   localparam int unsigned FQ_DATA_WIDTH = 32;

   typedef struct packed {
      logic [FQ_DATA_WIDTH-1:0] inst;
      logic [FQ_DATA_WIDTH-1:0] pc;
      logic [FQ_DATA_WIDTH-1:0] imm;
      logic [FQ_DATA_WIDTH-1:0] pc_at_pred;
      logic                     bp;
   } fq_entry_t;

   typedef enum logic {FQ_RUN, FQ_SQUASH} fq_state_t;

   // Number of consecutive ones starting at bit 0, looking at the low 'width' bits.
   function automatic int unsigned lead_ones_count(input logic [31:0] bits,
                                                   input int unsigned width);
      int unsigned n;
      logic        run;
      n   = 0;
      run = 1'b1;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < width && run) begin
            if (bits[i]) n++;
            else         run = 1'b0;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fq_lead_ones.sv
// Leading-ones counter (from bit 0) of a WIDTH-bit vector, WIDTH <= 32.
module fq_lead_ones
   import fetch_queue_pkg::*;
#(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0]             bits,
   output logic [$clog2(WIDTH+1)-1:0]   count_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   assign count_c = CNT_W'(lead_ones_count(32'(bits), WIDTH));

endmodule

// File: rtl/fetch_queue_param.sv
// Circular instruction queue between fetch and decode with post-flush squash.
// Define FETCH_QUEUE_PERF_EN to build the saturating performance counters.
module fetch_queue_param
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned FETCH_WIDTH   = 5,
   parameter int unsigned DECODE_WIDTH  = 3,
   parameter int unsigned SQUASH_CYCLES = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush_i,
   input  logic [FETCH_WIDTH-1:0]             fetch_valid_i,
   output logic                               fetch_ready_o,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  fetch_inst_i,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  fetch_pc_i,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  fetch_imm_i,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]  fetch_pc_at_pred_i,
   input  logic [FETCH_WIDTH-1:0]             fetch_bp_i,
   input  logic [DECODE_WIDTH-1:0]            decode_ready_i,
   output logic [DECODE_WIDTH-1:0]            decode_valid_o,
   output logic [DECODE_WIDTH*DATA_WIDTH-1:0] decode_inst_o,
   output logic [DECODE_WIDTH*DATA_WIDTH-1:0] decode_pc_o,
   output logic [DECODE_WIDTH*DATA_WIDTH-1:0] decode_imm_o,
   output logic [DECODE_WIDTH*DATA_WIDTH-1:0] decode_pc_at_pred_o,
   output logic [DECODE_WIDTH-1:0]            decode_bp_o,
   output logic                               buffer_empty_o,
   output logic                               buffer_full_o,
   output logic [$clog2(DEPTH):0]             occupancy_o,
   output logic [31:0]                        perf_full_stall_o,
   output logic [31:0]                        perf_empty_o,
   output logic [31:0]                        perf_flush_o
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned OCC_W  = PTR_W + 1;
   localparam int unsigned FCNT_W = $clog2(FETCH_WIDTH + 1);
   localparam int unsigned DCNT_W = $clog2(DECODE_WIDTH + 1);

   if (DATA_WIDTH != FQ_DATA_WIDTH || (DEPTH & (DEPTH - 1)) != 0 ||
       DEPTH < FETCH_WIDTH + DECODE_WIDTH || SQUASH_CYCLES > 7 ||
       FETCH_WIDTH > 32 || DECODE_WIDTH > 32) begin : g_param_check
      $error("fetch_queue_param: unsupported parameter combination");
   end

   fq_entry_t              mem [DEPTH];
   fq_state_t              state_q, state_d;
   logic [2:0]             sq_cnt_q, sq_cnt_d;
   logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic [FETCH_WIDTH-1:0] fetch_mask;
   logic                   mask_run;
   logic [FCNT_W-1:0]      n_in;
   logic [DCNT_W-1:0]      n_out;
   logic                   wr_en;

   // Readiness depends on pre-edge occupancy only; whole packets or nothing.
   assign fetch_ready_o  = (state_q == FQ_SQUASH) ||
                           ((OCC_W'(DEPTH) - occ_q) >= OCC_W'(FETCH_WIDTH));
   assign buffer_empty_o = (occ_q == '0);
   assign buffer_full_o  = (occ_q == OCC_W'(DEPTH));
   assign occupancy_o    = occ_q;
   assign wr_en          = fetch_ready_o && (state_q == FQ_RUN) && !flush_i;

   // Lanes after the first invalid one are ignored.
   always_comb begin
      mask_run   = 1'b1;
      fetch_mask = '0;
      for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
         mask_run      = mask_run & fetch_valid_i[k];
         fetch_mask[k] = mask_run;
      end
   end

   fq_lead_ones #(.WIDTH(FETCH_WIDTH)) u_fetch_cnt (
      .bits    (fetch_valid_i),
      .count_c (n_in)
   );

   fq_lead_ones #(.WIDTH(DECODE_WIDTH)) u_decode_cnt (
      .bits    (decode_valid_o & decode_ready_i),
      .count_c (n_out)
   );

   always_comb begin
      decode_valid_o = '0;
      for (int unsigned j = 0; j < DECODE_WIDTH; j++) begin
         decode_valid_o[j] = (state_q == FQ_RUN) && (occ_q > OCC_W'(j));
      end
   end

   // Head-ordered view of storage; lanes beyond occupancy read as zero.
   always_comb begin
      decode_inst_o       = '0;
      decode_pc_o         = '0;
      decode_imm_o        = '0;
      decode_pc_at_pred_o = '0;
      decode_bp_o         = '0;
      for (int unsigned j = 0; j < DECODE_WIDTH; j++) begin
         if (decode_valid_o[j]) begin
            decode_inst_o[j*DATA_WIDTH +: DATA_WIDTH]       = mem[head_q + PTR_W'(j)].inst;
            decode_pc_o[j*DATA_WIDTH +: DATA_WIDTH]         = mem[head_q + PTR_W'(j)].pc;
            decode_imm_o[j*DATA_WIDTH +: DATA_WIDTH]        = mem[head_q + PTR_W'(j)].imm;
            decode_pc_at_pred_o[j*DATA_WIDTH +: DATA_WIDTH] = mem[head_q + PTR_W'(j)].pc_at_pred;
            decode_bp_o[j]                                  = mem[head_q + PTR_W'(j)].bp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (fetch_mask[k]) begin
               mem[tail_q + PTR_W'(k)].inst       <= fetch_inst_i[k*DATA_WIDTH +: DATA_WIDTH];
               mem[tail_q + PTR_W'(k)].pc         <= fetch_pc_i[k*DATA_WIDTH +: DATA_WIDTH];
               mem[tail_q + PTR_W'(k)].imm        <= fetch_imm_i[k*DATA_WIDTH +: DATA_WIDTH];
               mem[tail_q + PTR_W'(k)].pc_at_pred <= fetch_pc_at_pred_i[k*DATA_WIDTH +: DATA_WIDTH];
               mem[tail_q + PTR_W'(k)].bp         <= fetch_bp_i[k];
            end
         end
      end
   end

   // Flush wins over everything; SQUASH drops fetch for SQUASH_CYCLES cycles.
   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      head_d   = head_q;
      tail_d   = tail_q;
      occ_d    = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
         if (SQUASH_CYCLES > 0) begin
            state_d  = FQ_SQUASH;
            sq_cnt_d = 3'(SQUASH_CYCLES);
         end else begin
            state_d  = FQ_RUN;
         end
      end else begin
         case (state_q)
            FQ_RUN: begin
               head_d = head_q + PTR_W'(n_out);
               if (wr_en) tail_d = tail_q + PTR_W'(n_in);
               occ_d = occ_q + (wr_en ? OCC_W'(n_in) : '0) - OCC_W'(n_out);
            end
            FQ_SQUASH: begin
               sq_cnt_d = sq_cnt_q - 3'd1;
               if (sq_cnt_q <= 3'd1) state_d = FQ_RUN;
            end
            default: state_d = FQ_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= FQ_RUN;
         sq_cnt_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         sq_cnt_q <= sq_cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         occ_q    <= occ_d;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] full_stall_q, empty_q, flush_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_stall_q <= '0;
         empty_q      <= '0;
         flush_q      <= '0;
      end else begin
         if (fetch_valid_i[0] && !fetch_ready_o && full_stall_q != '1)
            full_stall_q <= full_stall_q + 32'd1;
         if (buffer_empty_o && state_q == FQ_RUN && empty_q != '1)
            empty_q <= empty_q + 32'd1;
         if (flush_i && flush_q != '1)
            flush_q <= flush_q + 32'd1;
      end
   end

   assign perf_full_stall_o = full_stall_q;
   assign perf_empty_o      = empty_q;
   assign perf_flush_o      = flush_q;
`else
   assign perf_full_stall_o = '0;
   assign perf_empty_o      = '0;
   assign perf_flush_o      = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_param.sv
// Self-checking bench for fetch_queue_param: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_queue_param;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned FW    = 5;
   localparam int unsigned DECW  = 3;
   localparam int unsigned SQ    = 1;

   logic              clk;
   logic              rst_n;
   logic              flush_i;
   logic [FW-1:0]     fetch_valid_i;
   logic              fetch_ready_o;
   logic [FW*DW-1:0]  fetch_inst_i, fetch_pc_i, fetch_imm_i, fetch_pc_at_pred_i;
   logic [FW-1:0]     fetch_bp_i;
   logic [DECW-1:0]   decode_ready_i;
   logic [DECW-1:0]   decode_valid_o;
   logic [DECW*DW-1:0] decode_inst_o, decode_pc_o, decode_imm_o, decode_pc_at_pred_o;
   logic [DECW-1:0]   decode_bp_o;
   logic              buffer_empty_o, buffer_full_o;
   logic [4:0]        occupancy_o;
   logic [31:0]       perf_full_stall_o, perf_empty_o, perf_flush_o;

   fetch_queue_param #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .FETCH_WIDTH(FW),
      .DECODE_WIDTH(DECW), .SQUASH_CYCLES(SQ)
   ) dut (
      .clk(clk), .reset(rst_n), .flush_i(flush_i),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
      .fetch_inst_i(fetch_inst_i), .fetch_pc_i(fetch_pc_i),
      .fetch_imm_i(fetch_imm_i), .fetch_pc_at_pred_i(fetch_pc_at_pred_i),
      .fetch_bp_i(fetch_bp_i), .decode_ready_i(decode_ready_i),
      .decode_valid_o(decode_valid_o), .decode_inst_o(decode_inst_o),
      .decode_pc_o(decode_pc_o), .decode_imm_o(decode_imm_o),
      .decode_pc_at_pred_o(decode_pc_at_pred_o), .decode_bp_o(decode_bp_o),
      .buffer_empty_o(buffer_empty_o), .buffer_full_o(buffer_full_o),
      .occupancy_o(occupancy_o), .perf_full_stall_o(perf_full_stall_o),
      .perf_empty_o(perf_empty_o), .perf_flush_o(perf_flush_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] inst;
      logic [DW-1:0] pc;
      logic [DW-1:0] imm;
      logic [DW-1:0] pcp;
      logic          bp;
   } ent_t;

   typedef struct {
      logic [FW-1:0]   fv;
      logic [DECW-1:0] dr;
      logic [31:0]     pc;
      logic            exp_ready_pre;
      logic [4:0]      exp_occ;
      logic [DECW-1:0] exp_valid;
   } vec_t;

   ent_t        mq[$];
   int          sq_left;
   logic [31:0] m_full_stall, m_empty, m_flush;
   int          n_pass;
   int          n_total;
   vec_t        tbl[9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      sq_left      = 0;
      m_full_stall = '0;
      m_empty      = '0;
      m_flush      = '0;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      flush_i        = 1'b0;
      fetch_valid_i  = '0;
      decode_ready_i = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One clock: drive at negedge, compare against model, advance model at posedge.
   task automatic step(input logic [FW-1:0] fv, input logic [DECW-1:0] dr,
                       input logic fl, input logic [31:0] pc_base);
      int              sz, vis, nin, ndeq;
      logic            ready;
      logic [DECW*DW-1:0] e_inst, e_pc, e_imm, e_pcp;
      logic [DECW-1:0] e_bp, e_valid;
      ent_t            e;
      fetch_valid_i  = fv;
      decode_ready_i = dr;
      flush_i        = fl;
      for (int k = 0; k < FW; k++) begin
         fetch_inst_i[k*DW +: DW]       = $urandom;
         fetch_pc_i[k*DW +: DW]         = pc_base + 32'(4 * k);
         fetch_imm_i[k*DW +: DW]        = $urandom;
         fetch_pc_at_pred_i[k*DW +: DW] = $urandom;
         fetch_bp_i[k]                  = 1'($urandom);
      end
      #1;
      sz    = mq.size();
      ready = (sq_left > 0) || ((int'(DEPTH) - sz) >= int'(FW));
      vis   = (sq_left > 0) ? 0 : ((sz < int'(DECW)) ? sz : int'(DECW));
      e_inst = '0; e_pc = '0; e_imm = '0; e_pcp = '0; e_bp = '0; e_valid = '0;
      for (int j = 0; j < vis; j++) begin
         e_valid[j]           = 1'b1;
         e_inst[j*DW +: DW]   = mq[j].inst;
         e_pc[j*DW +: DW]     = mq[j].pc;
         e_imm[j*DW +: DW]    = mq[j].imm;
         e_pcp[j*DW +: DW]    = mq[j].pcp;
         e_bp[j]              = mq[j].bp;
      end
      chk("fetch_ready", 128'(fetch_ready_o), 128'(ready));
      chk("occupancy", 128'(occupancy_o), 128'(sz));
      chk("empty", 128'(buffer_empty_o), 128'(sz == 0));
      chk("full", 128'(buffer_full_o), 128'(sz == int'(DEPTH)));
      chk("decode_valid", 128'(decode_valid_o), 128'(e_valid));
      chk("decode_inst", 128'(decode_inst_o), 128'(e_inst));
      chk("decode_pc", 128'(decode_pc_o), 128'(e_pc));
      chk("decode_imm", 128'(decode_imm_o), 128'(e_imm));
      chk("decode_pc_at_pred", 128'(decode_pc_at_pred_o), 128'(e_pcp));
      chk("decode_bp", 128'(decode_bp_o), 128'(e_bp));
`ifdef FETCH_QUEUE_PERF_EN
      chk("perf_full_stall", 128'(perf_full_stall_o), 128'(m_full_stall));
      chk("perf_empty", 128'(perf_empty_o), 128'(m_empty));
      chk("perf_flush", 128'(perf_flush_o), 128'(m_flush));
`else
      chk("perf_tied_zero", 128'({perf_full_stall_o, perf_empty_o, perf_flush_o}), 128'(0));
`endif
      nin = 0;
      while (nin < int'(FW) && fv[nin]) nin++;
      ndeq = 0;
      while (ndeq < vis && dr[ndeq]) ndeq++;
      if (fv[0] && !ready) m_full_stall++;
      if (sz == 0 && sq_left == 0) m_empty++;
      if (fl) begin
         m_flush++;
         mq.delete();
         sq_left = int'(SQ);
      end else if (sq_left > 0) begin
         sq_left--;
      end else begin
         repeat (ndeq) void'(mq.pop_front());
         if (ready) begin
            for (int k = 0; k < nin; k++) begin
               e.inst = fetch_inst_i[k*DW +: DW];
               e.pc   = fetch_pc_i[k*DW +: DW];
               e.imm  = fetch_imm_i[k*DW +: DW];
               e.pcp  = fetch_pc_at_pred_i[k*DW +: DW];
               e.bp   = fetch_bp_i[k];
               mq.push_back(e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want $finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [FW-1:0]   fv;
      logic [DECW-1:0] dr;
      n_pass  = 0;
      n_total = 0;
      fetch_inst_i = '0; fetch_pc_i = '0; fetch_imm_i = '0;
      fetch_pc_at_pred_i = '0; fetch_bp_i = '0;

      tbl[0] = '{5'b00111, 3'b000, 32'h100, 1'b1, 5'd3,  3'b111};
      tbl[1] = '{5'b11111, 3'b000, 32'h200, 1'b1, 5'd8,  3'b111};
      tbl[2] = '{5'b01111, 3'b000, 32'h300, 1'b1, 5'd12, 3'b111};
      tbl[3] = '{5'b11111, 3'b000, 32'h400, 1'b0, 5'd12, 3'b111};
      tbl[4] = '{5'b00000, 3'b111, 32'h0,   1'b0, 5'd9,  3'b111};
      tbl[5] = '{5'b00000, 3'b111, 32'h0,   1'b1, 5'd6,  3'b111};
      tbl[6] = '{5'b00000, 3'b111, 32'h0,   1'b1, 5'd3,  3'b111};
      tbl[7] = '{5'b10101, 3'b101, 32'h500, 1'b1, 5'd3,  3'b111};
      tbl[8] = '{5'b00000, 3'b111, 32'h0,   1'b1, 5'd0,  3'b000};

      do_reset();
      chk("reset_occ", 128'(occupancy_o), 128'(0));
      chk("reset_flags", 128'({buffer_empty_o, buffer_full_o, fetch_ready_o}), 128'(3'b101));
      chk("reset_valid", 128'(decode_valid_o), 128'(0));

      for (int i = 0; i < 9; i++) begin
         chk("tbl_ready_pre", 128'(fetch_ready_o), 128'(tbl[i].exp_ready_pre));
         step(tbl[i].fv, tbl[i].dr, 1'b0, tbl[i].pc);
         chk("tbl_occ", 128'(occupancy_o), 128'(tbl[i].exp_occ));
         chk("tbl_valid", 128'(decode_valid_o), 128'(tbl[i].exp_valid));
         if (i == 0)
            chk("tbl_first_pcs", 128'(decode_pc_o), 128'({32'h108, 32'h104, 32'h100}));
         if (i == 7)
            chk("tbl_sparse_lane2_pc", 128'(decode_pc_o[2*DW +: DW]), 128'(32'h500));
      end

      // Wrap: head at 14, four entries straddling the end of storage.
      do_reset();
      step(5'b11111, 3'b000, 1'b0, 32'h1000);
      step(5'b11111, 3'b000, 1'b0, 32'h1100);
      step(5'b01111, 3'b000, 1'b0, 32'h1200);
      repeat (5) step(5'b00000, 3'b111, 1'b0, 32'h0);
      step(5'b01111, 3'b000, 1'b0, 32'h2000);
      step(5'b11111, 3'b011, 1'b0, 32'h3000);
      chk("wrap_occ", 128'(occupancy_o), 128'(7));
      chk("wrap_lane0_pc", 128'(decode_pc_o[DW-1:0]), 128'(32'h2008));

      // Flush with a simultaneous fetch, then one squashed packet.
      do_reset();
      step(5'b11111, 3'b000, 1'b0, 32'h4000);
      step(5'b00001, 3'b000, 1'b0, 32'h4100);
      step(5'b11111, 3'b000, 1'b1, 32'h4200);
      chk("flush_occ", 128'(occupancy_o), 128'(0));
      chk("squash_ready", 128'(fetch_ready_o), 128'(1));
      chk("squash_valid", 128'(decode_valid_o), 128'(0));
      step(5'b11111, 3'b000, 1'b0, 32'h4300);
      chk("squash_drop_occ", 128'(occupancy_o), 128'(0));
      step(5'b11111, 3'b000, 1'b0, 32'h4400);
      chk("post_squash_occ", 128'(occupancy_o), 128'(5));
      chk("post_squash_pc", 128'(decode_pc_o[DW-1:0]), 128'(32'h4400));

      // Asynchronous reset mid-operation, checked before the next clock edge.
      do_reset();
      step(5'b11111, 3'b000, 1'b0, 32'h5000);
      step(5'b01111, 3'b000, 1'b0, 32'h5100);
      chk("pre_async_occ", 128'(occupancy_o), 128'(9));
      #2 rst_n = 1'b0;
      #1;
      chk("async_occ", 128'(occupancy_o), 128'(0));
      chk("async_flags", 128'({buffer_empty_o, buffer_full_o, fetch_ready_o}), 128'(3'b101));
      chk("async_valid", 128'(decode_valid_o), 128'(0));
      chk("async_payload", 128'(decode_pc_o), 128'(0));
      chk("async_perf", 128'({perf_full_stall_o, perf_empty_o, perf_flush_o}), 128'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1) fv = FW'((1 << $urandom_range(0, FW)) - 1);
         else                           fv = FW'($urandom);
         dr = DECW'($urandom);
         step(fv, dr, ($urandom_range(0, 24) == 0), $urandom & 32'hFFFF_FFFC);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
